// File: rtl/mux_chan_scan_if.sv
// ============================================================================
//  Module   : mux_chan_scan_if
//  Brief    : Channel bank / consumer bundle for the scanning channel mux.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mux_chan_scan_if #(
   parameter int N_CH = 16,
   parameter int W    = 8
);
   localparam int SEL_W = $clog2(N_CH);

   logic [N_CH*W-1:0] a;
   logic [SEL_W-1:0]  sel;
   logic              mode;
   logic [N_CH-1:0]   ch_en;
   logic              start;
   logic [W-1:0]      y;
   logic [SEL_W-1:0]  y_ch;
   logic              y_valid;
   logic              y_ready;
   logic              busy;

   // master: sample banks plus downstream consumer; slave: the mux itself
   modport master (
      output a, sel, mode, ch_en, start, y_ready,
      input  y, y_ch, y_valid, busy
   );

   modport slave (
      input  a, sel, mode, ch_en, start, y_ready,
      output y, y_ch, y_valid, busy
   );
endinterface

`default_nettype wire

// File: rtl/mux_chan_scan.sv
// ============================================================================
//  Module   : mux_chan_scan
//  Brief    : Registered N-channel W-bit mux, valid/ready output, masked scan.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_chan_scan #(
   parameter int N_CH = 16,
   parameter int W    = 8
) (
   input wire logic         clk,
   input wire logic         rst_n,
   mux_chan_scan_if.slave   bus
);
   localparam int SEL_W = $clog2(N_CH);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [N_CH-1:0]   r_mask;
   logic [N_CH-1:0]   w_mask_nxt;
   logic [W-1:0]      r_y;
   logic [W-1:0]      w_y_nxt;
   logic [SEL_W-1:0]  r_y_ch;
   logic [SEL_W-1:0]  w_y_ch_nxt;
   logic              r_y_valid;
   logic              w_y_valid_nxt;

   logic [W-1:0]      w_ch_data [N_CH];
   logic [W-1:0]      w_sel_data;
   logic [W-1:0]      w_scan_data;
   logic [SEL_W-1:0]  w_low_idx;
   logic [N_CH-1:0]   w_mask_clr;
   logic              w_load_ok;

   for (genvar k = 0; k < N_CH; k++) begin : g_unpack
      assign w_ch_data[k] = bus.a[k*W +: W];
   end

   // Out-of-range selects (non power-of-two N_CH) fall through to zero
   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (bus.sel == SEL_W'(k)) begin
            w_sel_data = w_ch_data[k];
         end
      end
   end

   // Descending walk so the lowest set mask bit wins
   always_comb begin
      w_low_idx   = '0;
      w_scan_data = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (r_mask[k]) begin
            w_low_idx   = SEL_W'(k);
            w_scan_data = w_ch_data[k];
         end
      end
   end

   assign w_mask_clr = r_mask & (r_mask - 1'b1);
   assign w_load_ok  = !r_y_valid || bus.y_ready;

   always_comb begin
      w_state_nxt   = r_state;
      w_mask_nxt    = r_mask;
      w_y_nxt       = r_y;
      w_y_ch_nxt    = r_y_ch;
      w_y_valid_nxt = r_y_valid;
      case (r_state)
         IDLE: begin
            if (!bus.mode) begin
               if (w_load_ok) begin
                  w_y_nxt       = w_sel_data;
                  w_y_ch_nxt    = bus.sel;
                  w_y_valid_nxt = 1'b1;
               end
            end else begin
               if (w_load_ok) begin
                  w_y_valid_nxt = 1'b0;
               end
               if (bus.start && (|bus.ch_en)) begin
                  w_mask_nxt  = bus.ch_en;
                  w_state_nxt = SCAN;
               end
            end
         end
         SCAN: begin
            // Mask only advances on a load, so stalls never skip a channel
            if (w_load_ok) begin
               w_y_nxt       = w_scan_data;
               w_y_ch_nxt    = w_low_idx;
               w_y_valid_nxt = 1'b1;
               w_mask_nxt    = w_mask_clr;
               if (w_mask_clr == '0) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_mask    <= '0;
         r_y       <= '0;
         r_y_ch    <= '0;
         r_y_valid <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mask    <= w_mask_nxt;
         r_y       <= w_y_nxt;
         r_y_ch    <= w_y_ch_nxt;
         r_y_valid <= w_y_valid_nxt;
      end
   end

   assign bus.y       = r_y;
   assign bus.y_ch    = r_y_ch;
   assign bus.y_valid = r_y_valid;
   assign bus.busy    = (r_state == SCAN);

endmodule

`default_nettype wire

// File: tb/tb_mux_chan_scan.sv
// ============================================================================
//  Module   : tb_mux_chan_scan
//  Brief    : Scoreboard bench for mux_chan_scan (16x8 and 5x3 instances).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_chan_scan;
   localparam int N_CH = 16;
   localparam int W    = 8;
   localparam int N5   = 5;
   localparam int W5   = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   int exp_d[$];
   int exp_ch[$];
   int exp5_d[$];
   int exp5_ch[$];

   logic [W-1:0]  av  [N_CH];
   logic [W5-1:0] av5 [N5];

   logic         held_v  = 1'b0;
   logic [W-1:0] held_y  = '0;
   logic [3:0]   held_ch = '0;

   always #5 clk = ~clk;

   mux_chan_scan_if #(.N_CH(N_CH), .W(W))  bus  ();
   mux_chan_scan_if #(.N_CH(N5),   .W(W5)) bus5 ();

   mux_chan_scan #(.N_CH(N_CH), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mux_chan_scan #(.N_CH(N5), .W(W5)) dut5 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus5)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a16();
      for (int k = 0; k < N_CH; k++) bus.a[k*W +: W] = av[k];
   endtask

   task automatic drive_a5();
      for (int k = 0; k < N5; k++) bus5.a[k*W5 +: W5] = av5[k];
   endtask

   // Reference sweep: every enabled channel once, ascending, data as held on a
   task automatic push_scan16(input logic [N_CH-1:0] en);
      for (int k = 0; k < N_CH; k++) begin
         if (en[k]) begin
            exp_d.push_back(int'(av[k]));
            exp_ch.push_back(k);
         end
      end
   endtask

   task automatic drain16(input bit rnd);
      int n = 0;
      while ((exp_d.size() != 0 || bus.busy === 1'b1) && n < 400) begin
         bus.y_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
      end
      chk("drain16_timeout", 32'(n < 400), 32'd1);
      bus.y_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic busy_len16(output int cnt);
      cnt = 0;
      repeat (8) begin
         if (bus.busy === 1'b1) cnt++;
         tick();
      end
   endtask

   // Monitor for the 16x8 instance: pops on every accepted transfer
   always @(negedge clk) begin : mon16
      int ed;
      int ec;
      if (!rst_n) begin
         held_v <= 1'b0;
      end else begin
         if (held_v) begin
            checks++;
            if (bus.y !== held_y || bus.y_ch !== held_ch) begin
               failures++;
               $display("FAIL stall_hold: y=%0h ch=%0d expected y=%0h ch=%0d",
                        bus.y, bus.y_ch, held_y, held_ch);
            end
         end
         if (bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
            checks++;
            if (exp_d.size() == 0) begin
               failures++;
               $display("FAIL item16_extra: y=%0h ch=%0d expected no item", bus.y, bus.y_ch);
            end else begin
               ed = exp_d.pop_front();
               ec = exp_ch.pop_front();
               if (bus.y !== W'(ed) || bus.y_ch !== 4'(ec)) begin
                  failures++;
                  $display("FAIL item16: y=%0h ch=%0d expected y=%0h ch=%0d",
                           bus.y, bus.y_ch, ed, ec);
               end
            end
         end
         held_v  <= bus.y_valid && !bus.y_ready;
         held_y  <= bus.y;
         held_ch <= bus.y_ch;
      end
   end

   always @(negedge clk) begin : mon5
      int ed;
      int ec;
      if (rst_n && bus5.y_valid === 1'b1 && bus5.y_ready === 1'b1) begin
         checks++;
         if (exp5_d.size() == 0) begin
            failures++;
            $display("FAIL item5_extra: y=%0h ch=%0d expected no item", bus5.y, bus5.y_ch);
         end else begin
            ed = exp5_d.pop_front();
            ec = exp5_ch.pop_front();
            if (bus5.y !== W5'(ed) || bus5.y_ch !== 3'(ec)) begin
               failures++;
               $display("FAIL item5: y=%0h ch=%0d expected y=%0h ch=%0d",
                        bus5.y, bus5.y_ch, ed, ec);
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      int cnt;
      int n;
      logic [N_CH-1:0] en;

      bus.a = '0;  bus.sel = '0;  bus.mode = 1'b1;  bus.ch_en = '0;
      bus.start = 1'b0;  bus.y_ready = 1'b1;
      bus5.a = '0; bus5.sel = '0; bus5.mode = 1'b1; bus5.ch_en = '0;
      bus5.start = 1'b0; bus5.y_ready = 1'b1;

      // Reset values
      #1;
      chk("rst_y",       32'(bus.y),       32'd0);
      chk("rst_y_ch",    32'(bus.y_ch),    32'd0);
      chk("rst_y_valid", 32'(bus.y_valid), 32'd0);
      chk("rst_busy",    32'(bus.busy),    32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) begin
         tick();
         chk("idle_scan_mode_valid", 32'(bus.y_valid), 32'd0);
      end

      // Direct ramp: a[k] = 8'h10 + k, sel 0..15
      for (int k = 0; k < N_CH; k++) av[k] = W'(8'h10 + k);
      drive_a16();
      bus.mode = 1'b0;
      for (int s = 0; s < N_CH; s++) begin
         bus.sel = 4'(s);
         exp_d.push_back(int'(av[s]));
         exp_ch.push_back(s);
         tick();
         chk("direct_valid_cont", 32'(bus.y_valid), 32'd1);
      end
      bus.mode = 1'b1;
      tick();
      chk("direct_to_scan_valid_drop", 32'(bus.y_valid), 32'd0);

      // Direct, random data and select every cycle
      bus.mode = 1'b0;
      repeat (40) begin
         for (int k = 0; k < N_CH; k++) av[k] = W'($urandom);
         drive_a16();
         n = $urandom_range(0, N_CH - 1);
         bus.sel = 4'(n);
         exp_d.push_back(int'(av[n]));
         exp_ch.push_back(n);
         tick();
      end
      bus.mode = 1'b1;
      tick();

      // Scan 8421 with ready held high
      for (int k = 0; k < N_CH; k++) av[k] = W'(8'h10 + k);
      drive_a16();
      bus.ch_en = 16'h8421;
      bus.start = 1'b1;
      push_scan16(16'h8421);
      tick();
      bus.start = 1'b0;
      busy_len16(cnt);
      chk("busy_len_8421", 32'(cnt), 32'd4);
      chk("scan_done_q", 32'(exp_d.size()), 32'd0);

      // Same scan with a 3-cycle stall after the first item and a stray start
      bus.start = 1'b1;
      push_scan16(16'h8421);
      tick();
      bus.start = 1'b0;
      tick();
      bus.y_ready = 1'b0;
      bus.start   = 1'b1;
      bus.ch_en   = 16'hFFFF;
      repeat (3) tick();
      bus.start = 1'b0;
      bus.ch_en = 16'h8421;
      drain16(1'b0);

      // Empty mask start does nothing; single-channel mask gives one item
      bus.ch_en = '0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (3) begin
         chk("zero_mask_busy",  32'(bus.busy),    32'd0);
         chk("zero_mask_valid", 32'(bus.y_valid), 32'd0);
         tick();
      end
      bus.ch_en = 16'h0001;
      bus.start = 1'b1;
      push_scan16(16'h0001);
      tick();
      bus.start = 1'b0;
      busy_len16(cnt);
      chk("busy_len_0001", 32'(cnt), 32'd1);

      // Randomized sweeps under random back-pressure
      for (int i = 0; i < 20; i++) begin
         for (int k = 0; k < N_CH; k++) av[k] = W'($urandom);
         drive_a16();
         en = (i % 7 == 3) ? '0 : N_CH'($urandom_range(1, 16'hFFFF));
         bus.ch_en   = en;
         bus.y_ready = 1'b1;
         bus.start   = 1'b1;
         push_scan16(en);
         tick();
         bus.start = 1'b0;
         if (en == '0) chk("rand_zero_mask_busy", 32'(bus.busy), 32'd0);
         drain16(1'b1);
      end

      // Asynchronous reset mid-sweep with an item pending
      bus.ch_en   = 16'hFFFF;
      bus.y_ready = 1'b0;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("pre_rst_valid", 32'(bus.y_valid), 32'd1);
      chk("pre_rst_busy",  32'(bus.busy),    32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(bus.y_valid), 32'd0);
      chk("async_rst_busy",  32'(bus.busy),    32'd0);
      chk("async_rst_y",     32'(bus.y),       32'd0);
      chk("async_rst_y_ch",  32'(bus.y_ch),    32'd0);
      exp_d.delete();
      exp_ch.delete();
      bus.y_ready = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         chk("post_rst_valid", 32'(bus.y_valid), 32'd0);
         chk("post_rst_busy",  32'(bus.busy),    32'd0);
      end

      // 5-channel, 3-bit instance: out-of-range direct select, then scan
      for (int k = 0; k < N5; k++) av5[k] = W5'($urandom);
      drive_a5();
      bus5.mode = 1'b0;
      bus5.sel  = 3'd6;
      exp5_d.push_back(0);
      exp5_ch.push_back(6);
      tick();
      chk("n5_direct_valid", 32'(bus5.y_valid), 32'd1);
      bus5.sel = 3'd2;
      exp5_d.push_back(int'(av5[2]));
      exp5_ch.push_back(2);
      tick();
      bus5.mode = 1'b1;
      repeat (2) tick();
      bus5.ch_en = 5'b10110;
      bus5.start = 1'b1;
      for (int k = 0; k < N5; k++) begin
         if (bus5.ch_en[k]) begin
            exp5_d.push_back(int'(av5[k]));
            exp5_ch.push_back(k);
         end
      end
      tick();
      bus5.start = 1'b0;
      n = 0;
      while ((exp5_d.size() != 0 || bus5.busy === 1'b1) && n < 50) begin
         tick();
         n++;
      end
      chk("n5_scan_timeout", 32'(n < 50), 32'd1);
      repeat (2) tick();

      chk("q16_empty", 32'(exp_d.size()),  32'd0);
      chk("q5_empty",  32'(exp5_d.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/mux_chan_scan.md
Name: mux_chan_scan

Overview:
Parametrised, registered N-channel, W-bit multiplexer with a valid/ready output stage. It generalises the 16:1 single-bit selector with configurable width and channel count, and adds an auto-scan mode. In scan mode a start pulse triggers one ascending sweep over a masked set of channels, with back-pressure. It sits between channel sample banks and a single downstream consumer, for example a serialiser or a logger.

Parameters:
N_CH, 16, number of input channels (>= 2)
W, 8, data width per channel (>= 1)
SEL_W, $clog2(N_CH), derived localparam; channel index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
a  in  N_CH*W  packed channel data; channel k = a[k*W +: W]
sel  in  SEL_W  channel select, direct mode
mode  in  1  0 = direct, 1 = scan; sampled only in IDLE
ch_en  in  N_CH  scan channel mask; captured on accepted start
start  in  1  scan start pulse
y  out  W  registered selected data
y_ch  out  SEL_W  channel index of y
y_valid  out  1  y/y_ch valid
y_ready  in  1  downstream accepts when y_valid && y_ready
busy  out  1  scan sweep in progress

Behaviour:
- Reset (async assert, sync release): y=0, y_ch=0, y_valid=0, busy=0, state=IDLE, mask register=0.
- Output stage:
  - Register loads only when load_ok = !y_valid || y_ready.
  - While y_valid && !y_ready, y and y_ch stay bit-stable.
  - Latency from the input cycle to y is 1 clk.
- FSM states: IDLE, SCAN.
- IDLE, mode=0 (direct):
  - Every load_ok cycle: y <= a[sel], y_ch <= sel, y_valid <= 1.
  - y_valid therefore stays high continuously while the consumer keeps up.
  - sel >= N_CH (non-power-of-2 N_CH): y <= 0, y_ch <= sel, y_valid <= 1.
  - start is ignored in direct mode.
- IDLE, mode=1:
  - No new loads. A pending y is held until accepted, then y_valid <= 0.
  - start=1 with ch_en != 0: mask <= ch_en, state <= SCAN, busy <= 1 on the next edge.
  - start=1 with ch_en == 0: no effect. busy stays 0, no output.
- SCAN:
  - Each load_ok cycle, the lowest set bit k of mask is loaded: y <= a[k] (data sampled that cycle), y_ch <= k, y_valid <= 1, mask bit k cleared.
  - Disabled channels are skipped with zero bubble cycles.
  - One item per cycle when y_ready is held high.
  - When the final set bit is loaded, state <= IDLE and busy <= 0 on the same edge.
  - That last item stays valid until accepted, per the IDLE/mode=1 rule.
  - start, mode, sel and ch_en are ignored during SCAN; there is no restart mid-sweep.
- Back-pressure: with y_ready low, the mask does not advance, so no channel is skipped or duplicated.
- Mode change: mode is sampled only in IDLE. Switching 1->0 while idle with a held item resumes direct loads on the first load_ok cycle.
- Reset mid-sweep: everything clears immediately. No partial output survives, and y_valid is 0 the same instant rst_n falls.
- Sweep length equals popcount(ch_en). Channel order is strictly ascending.

Test Plan:
- Reset: drive rst_n=0 mid-operation with y_valid=1 -> all outputs 0 asynchronously; after release in IDLE mode=1, y_valid stays 0.
- Direct, N_CH=16, W=8, a[k]=8'h10+k, y_ready=1: sel sweeps 0..15 -> one cycle later y=8'h10+sel, y_ch=sel; y_valid high continuously.
- Scan with ch_en=16'h8421, y_ready=1, start pulse: y_ch=0,5,10,15 on four consecutive cycles with y=8'h10,15,1A,1F; busy high 4 cycles then low.
- Back-pressure: same scan with y_ready low for 3 cycles after the first item -> y_ch=0 held stable 4 cycles, then 5,10,15; no item lost or duplicated; a 2nd start during busy is ignored.
- ch_en=0 with start -> busy and y_valid stay 0. ch_en=16'h0001 -> exactly one item, ch 0, busy high 1 cycle.
- Parameter sweep N_CH=5, W=3: direct sel=6 -> y=0, y_ch=6, y_valid=1; scan with ch_en=5'b10110 -> y_ch=1,2,4.
